// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the fetch PC, drives the NPC mux select and arbitrates redirects
// (jalr > branch from EX, then jal from ID). It also handles the hazard stall,
// the external halt freeze and the IF/ID and ID/EX flush strobes. An EX
// redirect that arrives while halted is buffered and replayed on release.
// Ports:
//   clk, rstn             clock (rising edge), async active-low reset
//   npc_i                 next PC from the fetch mux selected by NPCOp_o
//   stall_i, halt_i       hazard stall, external fetch freeze
//   br_taken_i/br_target_i, jalr_i/jalr_target_i   EX redirects
//   jal_i                 ID jal redirect
//   PC_o                  current fetch PC (registered)
//   NPCOp_o               0=PC+4 1=branch 2=jal 3=jalr (combinational)
//   if_valid_o            fetched instruction valid (combinational)
//   flush_ifid_o/flush_idex_o   squash strobes (combinational)
//   pend_o                redirect buffered during halt (registered)
//   flush_cnt_o           saturating count of IF/ID flush cycles (registered)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned BOOT_DELAY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] npc_i,
  input  logic        stall_i,
  input  logic        halt_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        jalr_i,
  input  logic [31:0] jalr_target_i,
  input  logic        jal_i,
  output logic [31:0] PC_o,
  output logic [2:0]  NPCOp_o,
  output logic        if_valid_o,
  output logic        flush_ifid_o,
  output logic        flush_idex_o,
  output logic        pend_o,
  output logic [15:0] flush_cnt_o
);

  localparam int unsigned    CntW     = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  localparam logic [CntW-1:0] BootLast = CntW'(BOOT_DELAY - 1);

  localparam logic [2:0] OpPc4    = 3'd0;
  localparam logic [2:0] OpBranch = 3'd1;
  localparam logic [2:0] OpJal    = 3'd2;
  localparam logic [2:0] OpJalr   = 3'd3;

  typedef enum logic [1:0] {StBoot, StRun, StHalt, StHaltPend} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CntW-1:0] boot_cnt_q, boot_cnt_d;
  logic            pend_q, pend_d;
  logic [31:0]     pend_tgt_q, pend_tgt_d;
  logic [15:0]     flush_cnt_q, flush_cnt_d;

  logic        ex_rd;
  logic [31:0] ex_tgt;
  logic [2:0]  ex_op;

  assign ex_rd  = jalr_i | br_taken_i;
  assign ex_tgt = jalr_i ? jalr_target_i : br_target_i;
  assign ex_op  = jalr_i ? OpJalr : OpBranch;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    boot_cnt_d   = boot_cnt_q;
    pend_d       = pend_q;
    pend_tgt_d   = pend_tgt_q;
    NPCOp_o      = OpPc4;
    if_valid_o   = 1'b0;
    flush_ifid_o = 1'b0;
    flush_idex_o = 1'b0;

    unique case (state_q)
      StBoot: begin
        boot_cnt_d = boot_cnt_q + CntW'(1);
        if (boot_cnt_q == BootLast) begin
          boot_cnt_d = '0;
          state_d    = StRun;
        end
      end
      StRun: begin
        if_valid_o = ~halt_i & ~stall_i;
        if (ex_rd) begin
          // EX redirect wins over stall; under halt it is parked instead of taken.
          NPCOp_o      = ex_op;
          flush_ifid_o = 1'b1;
          flush_idex_o = 1'b1;
          if (halt_i) begin
            pend_d     = 1'b1;
            pend_tgt_d = ex_tgt;
            state_d    = StHaltPend;
          end else begin
            pc_d = npc_i;
          end
        end else if (halt_i) begin
          state_d = StHalt;
        end else if (stall_i) begin
          // Hold: a jal in the stalled ID slot is re-presented after the stall.
        end else if (jal_i) begin
          NPCOp_o      = OpJal;
          flush_ifid_o = 1'b1;
          pc_d         = npc_i;
        end else begin
          pc_d = npc_i;
        end
      end
      StHalt: begin
        if (ex_rd) begin
          flush_ifid_o = 1'b1;
          flush_idex_o = 1'b1;
          pend_d       = 1'b1;
          pend_tgt_d   = ex_tgt;
          state_d      = StHaltPend;
        end else if (!halt_i) begin
          state_d = StRun;
        end
      end
      StHaltPend: begin
        if (ex_rd) begin
          flush_ifid_o = 1'b1;
          flush_idex_o = 1'b1;
          pend_tgt_d   = ex_tgt;
        end
        if (!halt_i) begin
          // Replay the most recent redirect, including one arriving this cycle.
          pc_d         = ex_rd ? ex_tgt : pend_tgt_q;
          flush_ifid_o = 1'b1;
          pend_d       = 1'b0;
          state_d      = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush_ifid_o && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      boot_cnt_q  <= '0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      boot_cnt_q  <= boot_cnt_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PC_o        = pc_q;
  assign pend_o      = pend_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
